// File: rtl/register_file_param.sv
// Parametrised register bank: one write port, two registered read ports with
// same-cycle write-to-read forwarding and an optional hardwired-zero register 0.
module register_file_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              READ,
   input  logic [ADDR_W-1:0] RD_ADDR1,
   input  logic [ADDR_W-1:0] RD_ADDR2,
   output logic [DATA_W-1:0] RD_DATA1,
   output logic [DATA_W-1:0] RD_DATA2,
   output logic              RD_VALID
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_eff;
   logic [DATA_W-1:0] rd_next1;
   logic [DATA_W-1:0] rd_next2;

   // A write to register 0 is dropped entirely when it is hardwired to zero,
   // so it can never reach storage or the bypass path.
   assign wr_eff = WRITE && !(ZERO_REG && (WR_ADDR == '0));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_eff) begin
         regs[WR_ADDR] <= WR_DATA;
      end
   end

   always_comb begin
      rd_next1 = regs[RD_ADDR1];
      if (wr_eff && (RD_ADDR1 == WR_ADDR)) rd_next1 = WR_DATA;
      if (ZERO_REG && (RD_ADDR1 == '0))    rd_next1 = '0;
   end

   always_comb begin
      rd_next2 = regs[RD_ADDR2];
      if (wr_eff && (RD_ADDR2 == WR_ADDR)) rd_next2 = WR_DATA;
      if (ZERO_REG && (RD_ADDR2 == '0))    rd_next2 = '0;
   end

   // Read handshake: READ sampled high at edge N gives RD_VALID=1 and fresh
   // RD_DATA1/RD_DATA2 for exactly the cycle after edge N; there is no ready,
   // reads are never stalled, and data holds while READ is low.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         RD_DATA1 <= '0;
         RD_DATA2 <= '0;
         RD_VALID <= 1'b0;
      end else begin
         RD_VALID <= READ;
         if (READ) begin
            RD_DATA1 <= rd_next1;
            RD_DATA2 <= rd_next2;
         end
      end
   end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: 32x32 banks with and without the
// zero register, plus an 8-bit/8-entry bank for the sweep.
module tb_register_file_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // A (ZERO_REG=1) and B (ZERO_REG=0) share their inputs.
   logic        ab_write = 1'b0;
   logic [4:0]  ab_wr_addr = '0;
   logic [31:0] ab_wr_data = '0;
   logic        ab_read = 1'b0;
   logic [4:0]  ab_rd_addr1 = '0;
   logic [4:0]  ab_rd_addr2 = '0;
   logic [31:0] a_rd_data1, a_rd_data2, b_rd_data1, b_rd_data2;
   logic        a_rd_valid, b_rd_valid;

   logic        c_write = 1'b0;
   logic [2:0]  c_wr_addr = '0;
   logic [7:0]  c_wr_data = '0;
   logic        c_read = 1'b0;
   logic [2:0]  c_rd_addr1 = '0;
   logic [2:0]  c_rd_addr2 = '0;
   logic [7:0]  c_rd_data1, c_rd_data2;
   logic        c_rd_valid;

   register_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_a (
      .CLK(clk), .RESET(rst), .WRITE(ab_write), .WR_ADDR(ab_wr_addr), .WR_DATA(ab_wr_data),
      .READ(ab_read), .RD_ADDR1(ab_rd_addr1), .RD_ADDR2(ab_rd_addr2),
      .RD_DATA1(a_rd_data1), .RD_DATA2(a_rd_data2), .RD_VALID(a_rd_valid));

   register_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_b (
      .CLK(clk), .RESET(rst), .WRITE(ab_write), .WR_ADDR(ab_wr_addr), .WR_DATA(ab_wr_data),
      .READ(ab_read), .RD_ADDR1(ab_rd_addr1), .RD_ADDR2(ab_rd_addr2),
      .RD_DATA1(b_rd_data1), .RD_DATA2(b_rd_data2), .RD_VALID(b_rd_valid));

   register_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut_c (
      .CLK(clk), .RESET(rst), .WRITE(c_write), .WR_ADDR(c_wr_addr), .WR_DATA(c_wr_data),
      .READ(c_read), .RD_ADDR1(c_rd_addr1), .RD_ADDR2(c_rd_addr2),
      .RD_DATA1(c_rd_data1), .RD_DATA2(c_rd_data2), .RD_VALID(c_rd_valid));

   // Apply one cycle of stimulus, return 1ns after the edge, then idle the strobes.
   task automatic drive_ab(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                           input logic r, input logic [4:0] a1, input logic [4:0] a2);
      ab_write = w; ab_wr_addr = wa; ab_wr_data = wd;
      ab_read = r; ab_rd_addr1 = a1; ab_rd_addr2 = a2;
      @(posedge clk); #1;
      ab_write = 1'b0; ab_read = 1'b0;
   endtask

   task automatic drive_c(input logic w, input logic [2:0] wa, input logic [7:0] wd);
      c_write = w; c_wr_addr = wa; c_wr_data = wd; c_read = 1'b0;
      @(posedge clk); #1;
      c_write = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (a_rd_data1 !== 32'h0) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", a_rd_data1, 32'h0); end
      checks++; if (a_rd_data2 !== 32'h0) begin failures++; $display("FAIL reset_rd2 got=%h exp=%h", a_rd_data2, 32'h0); end
      checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_rd_valid); end
      @(negedge clk); rst = 1'b0;
      drive_ab(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
      drive_ab(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
      checks++; if (a_rd_data1 !== 32'hDEADBEEF) begin failures++; $display("FAIL preload_rd1 got=%h exp=%h", a_rd_data1, 32'hDEADBEEF); end
      // Leave a read pending (RD_VALID high), then reset between edges.
      ab_read = 1'b1; ab_rd_addr1 = 5'd5; ab_rd_addr2 = 5'd5;
      @(posedge clk); #1; ab_read = 1'b0;
      checks++; if (a_rd_valid !== 1'b1) begin failures++; $display("FAIL pending_valid got=%b exp=1", a_rd_valid); end
      #2; rst = 1'b1; #1;
      checks++; if (a_rd_data1 !== 32'h0) begin failures++; $display("FAIL async_rd1 got=%h exp=%h", a_rd_data1, 32'h0); end
      checks++; if (a_rd_data2 !== 32'h0) begin failures++; $display("FAIL async_rd2 got=%h exp=%h", a_rd_data2, 32'h0); end
      checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", a_rd_valid); end
      @(negedge clk); rst = 1'b0;
      drive_ab(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
      checks++; if (a_rd_data1 !== 32'h0) begin failures++; $display("FAIL post_reset_reg5 got=%h exp=%h", a_rd_data1, 32'h0); end
      checks++; if (a_rd_valid !== 1'b1) begin failures++; $display("FAIL post_reset_valid got=%b exp=1", a_rd_valid); end
   endtask

   task automatic test_write_read;
      drive_ab(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd0);
      drive_ab(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
      checks++; if (a_rd_data1 !== 32'h12345678) begin failures++; $display("FAIL wr_rd1 got=%h exp=%h", a_rd_data1, 32'h12345678); end
      checks++; if (a_rd_data2 !== 32'h12345678) begin failures++; $display("FAIL wr_rd2 got=%h exp=%h", a_rd_data2, 32'h12345678); end
      checks++; if (a_rd_valid !== 1'b1) begin failures++; $display("FAIL wr_valid got=%b exp=1", a_rd_valid); end
      ab_rd_addr1 = 5'd9; ab_rd_addr2 = 5'd10;
      @(posedge clk); #1;
      checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", a_rd_valid); end
      checks++; if (a_rd_data1 !== 32'h12345678) begin failures++; $display("FAIL hold_rd1 got=%h exp=%h", a_rd_data1, 32'h12345678); end
      checks++; if (a_rd_data2 !== 32'h12345678) begin failures++; $display("FAIL hold_rd2 got=%h exp=%h", a_rd_data2, 32'h12345678); end
   endtask

   task automatic test_bypass;
      drive_ab(1'b1, 5'd7, 32'h1111, 1'b0, 5'd0, 5'd0);
      drive_ab(1'b1, 5'd6, 32'h6666, 1'b0, 5'd0, 5'd0);
      drive_ab(1'b1, 5'd7, 32'h2222, 1'b1, 5'd7, 5'd6);
      checks++; if (a_rd_data1 !== 32'h2222) begin failures++; $display("FAIL bypass_rd1 got=%h exp=%h", a_rd_data1, 32'h2222); end
      checks++; if (a_rd_data2 !== 32'h6666) begin failures++; $display("FAIL bypass_rd2 got=%h exp=%h", a_rd_data2, 32'h6666); end
      drive_ab(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd7);
      checks++; if (a_rd_data2 !== 32'h2222) begin failures++; $display("FAIL bypass_stored got=%h exp=%h", a_rd_data2, 32'h2222); end
   endtask

   task automatic test_zero_reg;
      drive_ab(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
      checks++; if (a_rd_data1 !== 32'h0) begin failures++; $display("FAIL zero_byp_a1 got=%h exp=%h", a_rd_data1, 32'h0); end
      checks++; if (a_rd_data2 !== 32'h0) begin failures++; $display("FAIL zero_byp_a2 got=%h exp=%h", a_rd_data2, 32'h0); end
      checks++; if (b_rd_data1 !== 32'hFFFFFFFF) begin failures++; $display("FAIL nozero_byp_b1 got=%h exp=%h", b_rd_data1, 32'hFFFFFFFF); end
      drive_ab(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3);
      checks++; if (a_rd_data1 !== 32'h0) begin failures++; $display("FAIL zero_later_a1 got=%h exp=%h", a_rd_data1, 32'h0); end
      checks++; if (b_rd_data1 !== 32'hFFFFFFFF) begin failures++; $display("FAIL nozero_later_b1 got=%h exp=%h", b_rd_data1, 32'hFFFFFFFF); end
      checks++; if (b_rd_data2 !== 32'h12345678) begin failures++; $display("FAIL nozero_reg3_b2 got=%h exp=%h", b_rd_data2, 32'h12345678); end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) drive_c(1'b1, 3'(i), 8'(i * 17));
      for (int i = 0; i < 8; i++) begin
         logic [7:0] e1, e2;
         e1 = (i == 0) ? 8'd0 : 8'(i * 17);
         e2 = (i == 7) ? 8'd0 : 8'((7 - i) * 17);
         c_read = 1'b1; c_rd_addr1 = 3'(i); c_rd_addr2 = 3'(7 - i);
         @(posedge clk); #1;
         checks++; if (c_rd_data1 !== e1) begin failures++; $display("FAIL sweep_rd1[%0d] got=%h exp=%h", i, c_rd_data1, e1); end
         checks++; if (c_rd_data2 !== e2) begin failures++; $display("FAIL sweep_rd2[%0d] got=%h exp=%h", i, c_rd_data2, e2); end
         checks++; if (c_rd_valid !== 1'b1) begin failures++; $display("FAIL sweep_valid[%0d] got=%b exp=1", i, c_rd_valid); end
      end
      c_read = 1'b0;
   endtask

   task automatic test_reset_mid_write;
      @(negedge clk);
      rst = 1'b1; ab_write = 1'b1; ab_wr_addr = 5'd2; ab_wr_data = 32'hAB;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b0; ab_write = 1'b0;
      drive_ab(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2);
      checks++; if (a_rd_data1 !== 32'h0) begin failures++; $display("FAIL midwr_a1 got=%h exp=%h", a_rd_data1, 32'h0); end
      checks++; if (b_rd_data2 !== 32'h0) begin failures++; $display("FAIL midwr_b2 got=%h exp=%h", b_rd_data2, 32'h0); end
      checks++; if (a_rd_valid !== 1'b1) begin failures++; $display("FAIL midwr_valid got=%b exp=1", a_rd_valid); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_bypass;
      test_zero_reg;
      test_back_to_back;
      test_reset_mid_write;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
